// File: rtl/beam_timing_gen.sv
// beam_timing_gen: colour-clock driven beam counters producing hpos/vpos, syncs,
// blank and line/frame markers. Timing comes from fixed PAL/NTSC tables or from
// the programmable ECS-style registers when BEAMCON0.VARBEAMEN is set.
// Build option MINIMIG_BEAM_INTERLACE_EN adds long/short frame sequencing driven
// by lace, with short-frame vsync edges moved to mid-line.
// Assumes HW >= 9, 11 <= VW < 16 is not required; readback needs HW >= 9, VW >= 9, VW < 16.
`timescale 1ns/1ps
module beam_timing_gen #(
  parameter int HW        = 9,
  parameter int VW        = 11,
  parameter int PAL_HTOT  = 226,
  parameter int PAL_VTOT  = 312,
  parameter int NTSC_HTOT = 226,
  parameter int NTSC_VTOT = 262
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cck_en,
  input  logic          ntsc,
  input  logic          lace,
  input  logic          reg_wr,
  input  logic [7:0]    reg_address_in,
  input  logic [15:0]   data_in,
  output logic [15:0]   data_out,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          _hsync,
  output logic          _vsync,
  output logic          blank,
  output logic          eol,
  output logic          eof,
  output logic          lof,
  output logic [HW-1:0] htotal_out
);

  // Fixed-mode windows; identical horizontally for PAL and NTSC.
  localparam logic [HW-1:0] FIX_HSSTRT   = HW'(18);
  localparam logic [HW-1:0] FIX_HSSTOP   = HW'(35);
  localparam logic [HW-1:0] FIX_HBSTRT   = HW'(15);
  localparam logic [HW-1:0] FIX_HBSTOP   = HW'(53);
  localparam logic [VW-1:0] PAL_VSSTRT   = VW'(2);
  localparam logic [VW-1:0] PAL_VSSTOP   = VW'(5);
  localparam logic [VW-1:0] PAL_VBSTOP   = VW'(25);
  localparam logic [VW-1:0] NTSC_VSSTRT  = VW'(3);
  localparam logic [VW-1:0] NTSC_VSSTOP  = VW'(6);
  localparam logic [VW-1:0] NTSC_VBSTOP  = VW'(20);

  // Programmable timing registers (word addresses $1C0..$1E0 >> 1).
  logic [HW-1:0] htotal_r, hsstrt_r, hsstop_r, hbstrt_r, hbstop_r;
  logic [VW-1:0] vtotal_r, vsstrt_r, vsstop_r, vbstrt_r, vbstop_r;
  logic          varbeamen, hsytrue, vsytrue;

  // Active timing set selected by mode.
  logic [HW-1:0] htot, hs_start, hs_stop, hb_start, hb_stop, vedge;
  logic [VW-1:0] vtot, vlast, vs_start, vs_stop, vb_start, vb_stop;
  logic          next_lof;
  logic [1:0]    vpos_hi;

  // Half-open window [start,stop); start>stop wraps, start==stop never active.
  function automatic logic hwin(input logic [HW-1:0] pos, input logic [HW-1:0] start,
                                input logic [HW-1:0] stop);
    if (start == stop)     return 1'b0;
    else if (start < stop) return (pos >= start) && (pos < stop);
    else                   return (pos >= start) || (pos < stop);
  endfunction

  function automatic logic vwin(input logic [VW-1:0] pos, input logic [VW-1:0] start,
                                input logic [VW-1:0] stop);
    if (start == stop)     return 1'b0;
    else if (start < stop) return (pos >= start) && (pos < stop);
    else                   return (pos >= start) || (pos < stop);
  endfunction

  // Timing source mux: programmable registers or fixed PAL/NTSC table.
  always_comb begin
    htot     = HW'(PAL_HTOT);
    vtot     = VW'(PAL_VTOT);
    hs_start = FIX_HSSTRT;
    hs_stop  = FIX_HSSTOP;
    hb_start = FIX_HBSTRT;
    hb_stop  = FIX_HBSTOP;
    vs_start = PAL_VSSTRT;
    vs_stop  = PAL_VSSTOP;
    vb_start = '0;
    vb_stop  = PAL_VBSTOP;
    if (varbeamen) begin
      htot     = htotal_r;
      vtot     = vtotal_r;
      hs_start = hsstrt_r;
      hs_stop  = hsstop_r;
      hb_start = hbstrt_r;
      hb_stop  = hbstop_r;
      vs_start = vsstrt_r;
      vs_stop  = vsstop_r;
      vb_start = vbstrt_r;
      vb_stop  = vbstop_r;
    end else if (ntsc) begin
      htot     = HW'(NTSC_HTOT);
      vtot     = VW'(NTSC_VTOT);
      vs_start = NTSC_VSSTRT;
      vs_stop  = NTSC_VSSTOP;
      vb_stop  = NTSC_VBSTOP;
    end
  end

  assign htotal_out = htot;
  assign vlast      = lof ? vtot : vtot - VW'(1);

`ifdef MINIMIG_BEAM_INTERLACE_EN
  assign next_lof = lace ? ~lof : 1'b1;
  assign vedge    = lof ? '0 : HW'(({1'b0, htot} + {{HW{1'b0}}, 1'b1}) >> 1);
  logic unused_data;
  assign unused_data = ^data_in[15:VW];
`else
  assign next_lof = 1'b1;
  assign vedge    = '0;
  logic unused_inputs;
  assign unused_inputs = ^{data_in[15:VW], lace};
`endif

  // Upper vertical bits for VPOSR, present only when the counter is wide enough.
  if (VW > 10) begin : g_vhi2
    assign vpos_hi = vpos[10:9];
  end else if (VW > 9) begin : g_vhi1
    assign vpos_hi = {1'b0, vpos[9]};
  end else begin : g_vhi0
    assign vpos_hi = 2'b00;
  end

  // Beam counters: horizontal wrap on >= so a lowered total takes effect at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos <= '0;
      vpos <= '0;
      eol  <= 1'b0;
      eof  <= 1'b0;
      lof  <= 1'b1;
    end else begin
      eol <= 1'b0;
      eof <= 1'b0;
      if (cck_en) begin
        if (hpos >= htot) begin
          hpos <= '0;
          eol  <= 1'b1;
          if (vpos >= vlast) begin
            vpos <= '0;
            eof  <= 1'b1;
            lof  <= next_lof;
          end else begin
            vpos <= vpos + VW'(1);
          end
        end else begin
          hpos <= hpos + HW'(1);
        end
      end
    end
  end

  // Register file writes; new values are seen by the counters one clk later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      htotal_r  <= '0;
      hsstrt_r  <= '0;
      hsstop_r  <= '0;
      hbstrt_r  <= '0;
      hbstop_r  <= '0;
      vtotal_r  <= '0;
      vsstrt_r  <= '0;
      vsstop_r  <= '0;
      vbstrt_r  <= '0;
      vbstop_r  <= '0;
      varbeamen <= 1'b0;
      hsytrue   <= 1'b0;
      vsytrue   <= 1'b0;
    end else if (reg_wr) begin
      case (reg_address_in)
        8'hE0: htotal_r <= data_in[HW-1:0];
        8'hE1: hsstop_r <= data_in[HW-1:0];
        8'hE2: hbstrt_r <= data_in[HW-1:0];
        8'hE3: hbstop_r <= data_in[HW-1:0];
        8'hE4: vtotal_r <= data_in[VW-1:0];
        8'hE5: vsstop_r <= data_in[VW-1:0];
        8'hE6: vbstrt_r <= data_in[VW-1:0];
        8'hE7: vbstop_r <= data_in[VW-1:0];
        8'hEE: begin
          varbeamen <= data_in[7];
          hsytrue   <= data_in[3];
          vsytrue   <= data_in[2];
        end
        8'hEF: hsstrt_r <= data_in[HW-1:0];
        8'hF0: vsstrt_r <= data_in[VW-1:0];
        default: ;
      endcase
    end
  end

  // Registered sync/blank; vsync only moves at the line edge for this frame type.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      _hsync <= 1'b1;
      _vsync <= 1'b1;
      blank  <= 1'b1;
    end else begin
      _hsync <= ~(hwin(hpos, hs_start, hs_stop) ^ hsytrue);
      blank  <= hwin(hpos, hb_start, hb_stop) | vwin(vpos, vb_start, vb_stop);
      if (hpos == vedge)
        _vsync <= ~(vwin(vpos, vs_start, vs_stop) ^ vsytrue);
    end
  end

  // Readback of VPOSR/VHPOSR onto the OR-bus, zero when not addressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else begin
      case (reg_address_in)
        8'h02:   data_out <= {lof, 12'b0, vpos_hi, vpos[8]};
        8'h03:   data_out <= {vpos[7:0], hpos[8:1]};
        default: data_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_timing_gen.sv
// Testbench for beam_timing_gen: reset values, fixed PAL line length, cck gating,
// readback, programmable totals, a table of window probes, total rewrites around
// the wrap, asynchronous reset mid-line, and frame/vsync sequencing (both builds).
`timescale 1ns/1ps
module tb_beam_timing_gen;
  localparam int HW = 9;
  localparam int VW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cck_en = 1'b0;
  logic          ntsc = 1'b0;
  logic          lace = 1'b0;
  logic          reg_wr = 1'b0;
  logic [7:0]    reg_address_in = 8'h00;
  logic [15:0]   data_in = 16'h0000;
  logic [15:0]   data_out;
  logic [HW-1:0] hpos, htotal_out;
  logic [VW-1:0] vpos;
  logic          hsync_n, vsync_n, blank, eol, eof, lof;

  int checks = 0;
  int errors = 0;

`ifdef MINIMIG_BEAM_INTERLACE_EN
  localparam logic LACE_BUILD = 1'b1;
`else
  localparam logic LACE_BUILD = 1'b0;
`endif

  typedef struct {
    logic       is_blank;
    logic [8:0] start;
    logic [8:0] stop;
    logic [8:0] pos;
    logic       exp;
    string      name;
  } win_vec_t;

  win_vec_t vecs[12];

  beam_timing_gen dut (
    .clk(clk), .reset(reset), .cck_en(cck_en), .ntsc(ntsc), .lace(lace),
    .reg_wr(reg_wr), .reg_address_in(reg_address_in), .data_in(data_in),
    .data_out(data_out), .hpos(hpos), .vpos(vpos), ._hsync(hsync_n),
    ._vsync(vsync_n), .blank(blank), .eol(eol), .eof(eof), .lof(lof),
    .htotal_out(htotal_out)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [15:0] d);
    reg_wr = 1'b1; reg_address_in = a; data_in = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic pulse_cck(input int n);
    repeat (n) begin
      cck_en = 1'b1;
      @(negedge clk);
    end
    cck_en = 1'b0;
  endtask

  task automatic do_reset();
    cck_en = 1'b0;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  // counts clocks until eol (sel=0) or eof (sel=1) is seen, bounded
  task automatic wait_flag(input string name, input int sel, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((((sel == 0) ? eol : eof) !== 1'b1) && n < limit);
    if (((sel == 0) ? eol : eof) !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d clocks", name, n);
    end
  endtask

  task automatic wait_hpos(input string name, input logic [8:0] pos);
    int n;
    n = 0;
    while (hpos !== pos && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (hpos !== pos) begin
      checks++; errors++;
      $display("FAIL %s: hpos %0d never reached", name, pos);
    end
  endtask

  initial begin
    int n;
    // window probe table with HTOTAL=99, HSYTRUE=1 (hsync high inside window)
    vecs[0]  = '{1'b0, 9'd10, 9'd20, 9'd9,  1'b0, "hs_pos9"};
    vecs[1]  = '{1'b0, 9'd10, 9'd20, 9'd10, 1'b1, "hs_pos10"};
    vecs[2]  = '{1'b0, 9'd10, 9'd20, 9'd19, 1'b1, "hs_pos19"};
    vecs[3]  = '{1'b0, 9'd10, 9'd20, 9'd20, 1'b0, "hs_pos20"};
    vecs[4]  = '{1'b1, 9'd90, 9'd5,  9'd89, 1'b0, "hb_wrap_pos89"};
    vecs[5]  = '{1'b1, 9'd90, 9'd5,  9'd90, 1'b1, "hb_wrap_pos90"};
    vecs[6]  = '{1'b1, 9'd90, 9'd5,  9'd99, 1'b1, "hb_wrap_pos99"};
    vecs[7]  = '{1'b1, 9'd90, 9'd5,  9'd0,  1'b1, "hb_wrap_pos0"};
    vecs[8]  = '{1'b1, 9'd90, 9'd5,  9'd4,  1'b1, "hb_wrap_pos4"};
    vecs[9]  = '{1'b1, 9'd90, 9'd5,  9'd5,  1'b0, "hb_wrap_pos5"};
    vecs[10] = '{1'b0, 9'd30, 9'd30, 9'd30, 1'b0, "hs_empty_pos30"};
    vecs[11] = '{1'b1, 9'd40, 9'd41, 9'd40, 1'b1, "hb_single_pos40"};

    // reset values
    @(negedge clk);
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_lof", lof, 1);
    check("rst_eol", eol, 0);
    check("rst_eof", eof, 0);
    check("rst_blank", blank, 1);
    check("rst_hsync", hsync_n, 1);
    check("rst_vsync", vsync_n, 1);
    check("rst_data_out", data_out, 0);
    check("rst_htotal_pal", htotal_out, 226);
    ntsc = 1'b1;
    #1 check("htotal_ntsc", htotal_out, 226);
    ntsc = 1'b0;

    // fixed PAL line length and cck gating
    @(negedge clk);
    reset = 1'b1; cck_en = 1'b1;
    wait_flag("pal_eol1", 0, 400, n);
    check("pal_first_line_len", n, 227);
    check("pal_wrap_hpos", hpos, 0);
    check("pal_wrap_vpos", vpos, 1);
    wait_flag("pal_eol2", 0, 400, n);
    check("pal_line_len", n, 227);
    check("pal_vpos2", vpos, 2);
    cck_en = 1'b0;
    idle(5);
    check("gated_hpos", hpos, 0);
    pulse_cck(3);
    check("gated_step_hpos", hpos, 3);

    // readback at a known position (300 cck -> vpos 1, hpos 73)
    do_reset();
    pulse_cck(300);
    reg_address_in = 8'h03; idle(1);
    check("rd_vhposr", data_out, 16'h0124);
    reg_address_in = 8'h02; idle(1);
    check("rd_vposr", data_out, 16'h8000);
    reg_address_in = 8'h01; idle(1);
    check("rd_unaddressed", data_out, 16'h0000);

    // programmable totals: HTOTAL=99, VTOTAL=4, VARBEAMEN|HSYTRUE
    do_reset();
    wr_reg(8'hE0, 16'd99);
    wr_reg(8'hE4, 16'd4);
    wr_reg(8'hEE, 16'h0088);
    check("var_htotal_out", htotal_out, 99);
    cck_en = 1'b1;
    wait_flag("var_eol", 0, 300, n);
    check("var_line_len", n, 100);
    wait_flag("var_eof", 1, 1000, n);
    check("var_frame_rest", n, 400);
    check("var_eof_with_eol", eol, 1);
    check("var_eof_vpos", vpos, 0);

    // window table, counter free-running
    foreach (vecs[i]) begin
      wr_reg(vecs[i].is_blank ? 8'hE2 : 8'hEF, {7'd0, vecs[i].start});
      wr_reg(vecs[i].is_blank ? 8'hE3 : 8'hE1, {7'd0, vecs[i].stop});
      wait_hpos(vecs[i].name, vecs[i].pos);
      @(negedge clk);
      check(vecs[i].name, vecs[i].is_blank ? blank : hsync_n, vecs[i].exp);
    end
    cck_en = 1'b0;

    // total rewritten below hpos, and a write coinciding with a wrap
    do_reset();
    wr_reg(8'hE0, 16'd200);
    wr_reg(8'hE4, 16'd100);
    wr_reg(8'hEE, 16'h0088);
    pulse_cck(120);
    check("pre_shrink_hpos", hpos, 120);
    wr_reg(8'hE0, 16'd50);
    pulse_cck(1);
    check("shrink_wrap_hpos", hpos, 0);
    check("shrink_wrap_eol", eol, 1);
    check("shrink_wrap_vpos", vpos, 1);
    pulse_cck(50);
    check("at_total_hpos", hpos, 50);
    cck_en = 1'b1;
    wr_reg(8'hE0, 16'd60);
    cck_en = 1'b0;
    check("wr_wrap_old_total_hpos", hpos, 0);
    check("wr_wrap_old_total_eol", eol, 1);
    pulse_cck(51);
    check("new_total_no_wrap", hpos, 51);
    pulse_cck(9);
    pulse_cck(1);
    check("new_total_wrap_hpos", hpos, 0);
    check("new_total_wrap_vpos", vpos, 3);

    // asynchronous reset in mid-line
    reg_address_in = 8'h03;
    pulse_cck(30);
    idle(1);
    check("pre_rst_data_out", data_out, 16'h030F);
    check("pre_rst_hsync", hsync_n, 0);
    reset = 1'b0;
    #1;
    check("async_rst_hpos", hpos, 0);
    check("async_rst_vpos", vpos, 0);
    check("async_rst_lof", lof, 1);
    check("async_rst_blank", blank, 1);
    check("async_rst_hsync", hsync_n, 1);
    check("async_rst_data_out", data_out, 0);
    check("async_rst_htotal", htotal_out, 226);
    @(negedge clk);
    reset = 1'b1;

    // vsync/vblank windows and long/short frame sequencing with lace=1
    do_reset();
    lace = 1'b1;
    wr_reg(8'hE0, 16'd99);
    wr_reg(8'hE4, 16'd4);
    wr_reg(8'hF0, 16'd1);
    wr_reg(8'hE5, 16'd2);
    wr_reg(8'hE6, 16'd1);
    wr_reg(8'hE7, 16'd2);
    wr_reg(8'hEE, 16'h0084);
    idle(1);
    check("vs_line0", vsync_n, 0);
    check("vb_line0", blank, 0);
    pulse_cck(100);
    check("vs_line1_pre", vsync_n, 0);
    check("vb_line1_pre", blank, 0);
    idle(1);
    check("vs_line1", vsync_n, 1);
    check("vb_line1", blank, 1);
    pulse_cck(400);
    check("long_frame_eof", eof, 1);
    check("long_frame_vpos", vpos, 0);
    check("lof_after_long", lof, LACE_BUILD ? 0 : 1);
    pulse_cck(100);
    idle(1);
    check("vs_short_hpos0", vsync_n, LACE_BUILD ? 0 : 1);
    pulse_cck(50);
    idle(1);
    check("vs_short_hpos50", vsync_n, 1);
    pulse_cck(250);
    check("short_frame_eof", eof, LACE_BUILD ? 1 : 0);
    check("short_frame_vpos", vpos, LACE_BUILD ? 0 : 4);
    check("lof_after_short", lof, 1);
    lace = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
